// File: rtl/control_unit_mc.sv
// Multicycle control unit: fetches 16-bit instructions and sequences the
// DataPath control lines and a bounded-wait data-memory handshake.
module control_unit_mc #(
    parameter int PC_W      = 7,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [15:0]          I_Data,
    output logic [PC_W-1:0]      I_Addr,
    input  logic                 D_Ack,
    input  logic                 Z,
    output logic                 D_Req,
    output logic                 D_Wr,
    output logic [D_ADDR_W-1:0]  D_Addr,
    output logic                 RF_s,
    output logic                 RF_W_en,
    output logic [RF_ADDR_W-1:0] RF_W_Addr,
    output logic [RF_ADDR_W-1:0] RF_Ra_Addr,
    output logic [RF_ADDR_W-1:0] RF_Rb_Addr,
    output logic [2:0]           Alu_s0,
    output logic [3:0]           State,
    output logic [3:0]           NextState,
    output logic [15:0]          IR_Out,
    output logic [PC_W-1:0]      PC_Out,
    output logic                 Halted,
    output logic                 Fault
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;
    localparam logic [3:0] S_JZ     = 4'd10;
    localparam logic [3:0] S_JMP    = 4'd11;
    localparam logic [3:0] S_FAULT  = 4'd12;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    logic [3:0]      state_q;
    logic [3:0]      next_state;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [7:0]      wait_q;
    logic [3:0]      opcode;
    logic [7:0]      ld_field;
    logic [7:0]      st_field;
    logic            waiting;

    assign opcode   = ir_q[15:12];
    assign ld_field = ir_q[11:4];
    assign st_field = ir_q[7:0];
    assign waiting  = (state_q == S_LOAD_A) || (state_q == S_STORE);

    always_comb begin
        next_state = S_INIT;
        case (state_q)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'h1:    next_state = S_LOAD_A;
                    4'h2:    next_state = S_STORE;
                    4'h3:    next_state = S_ADD;
                    4'h4:    next_state = S_SUB;
                    4'h5:    next_state = S_HALT;
                    4'h6:    next_state = S_JZ;
                    4'h7:    next_state = S_JMP;
                    default: next_state = S_NOOP;
                endcase
            end
            S_NOOP, S_LOAD_B, S_ADD, S_SUB, S_JZ, S_JMP:
                next_state = S_FETCH;
            // an acknowledge in the last allowed cycle still wins over the timeout
            S_LOAD_A: begin
                if (D_Ack)                   next_state = S_LOAD_B;
                else if (wait_q >= WAIT_LAST) next_state = S_FAULT;
                else                         next_state = S_LOAD_A;
            end
            S_STORE: begin
                if (D_Ack)                   next_state = S_FETCH;
                else if (wait_q >= WAIT_LAST) next_state = S_FAULT;
                else                         next_state = S_STORE;
            end
            S_HALT:   next_state = S_HALT;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= next_state;
            if (waiting && (next_state == state_q)) wait_q <= wait_q + 8'd1;
            else                                   wait_q <= '0;
            case (state_q)
                S_FETCH: begin
                    ir_q <= I_Data;
                    pc_q <= pc_q + PC_W'(1);
                end
                S_JZ:    if (Z) pc_q <= ir_q[PC_W-1:0];
                S_JMP:   pc_q <= ir_q[PC_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        D_Req      = 1'b0;
        D_Wr       = 1'b0;
        D_Addr     = '0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_Addr  = '0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        Alu_s0     = 3'b000;
        // register addresses follow IR from DECODE until the next FETCH
        if (state_q >= S_DECODE && state_q <= S_FAULT) begin
            RF_Ra_Addr = ir_q[11:8];
            RF_Rb_Addr = ir_q[7:4];
        end
        case (state_q)
            S_LOAD_A: begin
                D_Req  = 1'b1;
                D_Addr = ld_field[D_ADDR_W-1:0];
            end
            S_STORE: begin
                D_Req  = 1'b1;
                D_Wr   = 1'b1;
                D_Addr = st_field[D_ADDR_W-1:0];
            end
            S_LOAD_B: begin
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_Addr = ir_q[3:0];
            end
            S_ADD: begin
                RF_W_en   = 1'b1;
                RF_W_Addr = ir_q[3:0];
                Alu_s0    = 3'b001;
            end
            S_SUB: begin
                RF_W_en   = 1'b1;
                RF_W_Addr = ir_q[3:0];
                Alu_s0    = 3'b010;
            end
            default: ;
        endcase
    end

    assign I_Addr    = pc_q;
    assign PC_Out    = pc_q;
    assign IR_Out    = ir_q;
    assign State     = state_q;
    assign NextState = next_state;
    assign Halted    = (state_q == S_HALT);
    assign Fault     = (state_q == S_FAULT);

endmodule
